// File: rtl/gcn_argmax_classifier.sv
// Argmax classifier for the GCN result memory: walks each node row, scans its
// class scores serially and records the index of the largest score per node.
module gcn_argmax_classifier #(
  parameter int unsigned FEATURE_ROWS   = 6,
  parameter int unsigned WEIGHT_COLS    = 3,
  parameter int unsigned DOT_PROD_WIDTH = 16,
  parameter int unsigned WEIGHT_WIDTH   = $clog2(WEIGHT_COLS),
  parameter int unsigned FEATURE_WIDTH  = $clog2(FEATURE_ROWS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  output logic [FEATURE_WIDTH-1:0]  read_row,
  input  logic [DOT_PROD_WIDTH-1:0] fm_wm_adj_out [0:WEIGHT_COLS-1],
  output logic [WEIGHT_WIDTH-1:0]   y             [0:FEATURE_ROWS-1],
  output logic                      busy,
  output logic                      done
);

  localparam logic [WEIGHT_WIDTH-1:0]  LAST_COL = WEIGHT_WIDTH'(WEIGHT_COLS - 1);
  localparam logic [FEATURE_WIDTH-1:0] LAST_ROW = FEATURE_WIDTH'(FEATURE_ROWS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CMP,
    S_STORE,
    S_DONE
  } state_t;

  state_t                    state,     state_nxt;
  logic [FEATURE_WIDTH-1:0]  row_cnt,   row_cnt_nxt;
  logic [WEIGHT_WIDTH-1:0]   col_cnt,   col_cnt_nxt;
  logic [DOT_PROD_WIDTH-1:0] max_val,   max_val_nxt;
  logic [WEIGHT_WIDTH-1:0]   max_idx,   max_idx_nxt;
  logic [DOT_PROD_WIDTH-1:0] row_buf     [0:WEIGHT_COLS-1];
  logic [DOT_PROD_WIDTH-1:0] row_buf_nxt [0:WEIGHT_COLS-1];
  logic [WEIGHT_WIDTH-1:0]   y_nxt       [0:FEATURE_ROWS-1];
  logic                      busy_nxt;
  logic                      done_nxt;

  // The row counter is the memory address; it only moves in IDLE and STORE.
  assign read_row = row_cnt;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      row_cnt <= '0;
      col_cnt <= '0;
      max_val <= '0;
      max_idx <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      for (int c = 0; c < int'(WEIGHT_COLS); c++) begin
        row_buf[c] <= '0;
      end
      for (int r = 0; r < int'(FEATURE_ROWS); r++) begin
        y[r] <= '0;
      end
    end else begin
      state   <= state_nxt;
      row_cnt <= row_cnt_nxt;
      col_cnt <= col_cnt_nxt;
      max_val <= max_val_nxt;
      max_idx <= max_idx_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
      for (int c = 0; c < int'(WEIGHT_COLS); c++) begin
        row_buf[c] <= row_buf_nxt[c];
      end
      for (int r = 0; r < int'(FEATURE_ROWS); r++) begin
        y[r] <= y_nxt[r];
      end
    end
  end

  // Next-state and datapath update; every register holds unless its state acts.
  always_comb begin
    state_nxt   = state;
    row_cnt_nxt = row_cnt;
    col_cnt_nxt = col_cnt;
    max_val_nxt = max_val;
    max_idx_nxt = max_idx;
    for (int c = 0; c < int'(WEIGHT_COLS); c++) begin
      row_buf_nxt[c] = row_buf[c];
    end
    for (int r = 0; r < int'(FEATURE_ROWS); r++) begin
      y_nxt[r] = y[r];
    end

    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt   = S_LOAD;
          row_cnt_nxt = '0;
          for (int r = 0; r < int'(FEATURE_ROWS); r++) begin
            y_nxt[r] = '0;
          end
        end
      end

      S_LOAD: begin
        for (int c = 0; c < int'(WEIGHT_COLS); c++) begin
          row_buf_nxt[c] = fm_wm_adj_out[c];
        end
        max_val_nxt = fm_wm_adj_out[0];
        max_idx_nxt = '0;
        col_cnt_nxt = WEIGHT_WIDTH'(1);
        state_nxt   = (WEIGHT_COLS == 1) ? S_STORE : S_CMP;
      end

      // Strict compare so that ties keep the earlier (lower) class index.
      S_CMP: begin
        if (row_buf[col_cnt] > max_val) begin
          max_val_nxt = row_buf[col_cnt];
          max_idx_nxt = col_cnt;
        end
        if (col_cnt == LAST_COL) begin
          state_nxt = S_STORE;
        end else begin
          col_cnt_nxt = col_cnt + WEIGHT_WIDTH'(1);
        end
      end

      S_STORE: begin
        y_nxt[row_cnt] = max_idx;
        if (row_cnt == LAST_ROW) begin
          state_nxt = S_DONE;
        end else begin
          row_cnt_nxt = row_cnt + FEATURE_WIDTH'(1);
          state_nxt   = S_LOAD;
        end
      end

      S_DONE: begin
        state_nxt = S_IDLE;
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    busy_nxt = (state_nxt == S_LOAD) || (state_nxt == S_CMP) || (state_nxt == S_STORE);
    done_nxt = (state_nxt == S_DONE);
  end

endmodule

// File: tb/tb_gcn_argmax_classifier.sv
// Scoreboard bench for gcn_argmax_classifier: expected class vectors are queued
// when a pass is launched and compared when done pulses.
module tb_gcn_argmax_classifier;

  localparam int unsigned FR = 6;
  localparam int unsigned WC = 3;
  localparam int unsigned DW = 16;
  localparam int unsigned WW = 2;
  localparam int unsigned FW = 3;
  localparam int unsigned YW = FR * WW;

  logic          clk   = 1'b0;
  logic          rst   = 1'b0;
  logic          start = 1'b0;
  logic [FW-1:0] read_row;
  logic [DW-1:0] mem_rd [0:WC-1];
  logic [WW-1:0] y      [0:FR-1];
  logic          busy;
  logic          done;

  logic [DW-1:0] mem [0:FR-1][0:WC-1];
  logic [YW-1:0] exp_q [$];
  int            n_cmp = 0;
  int            n_err = 0;

  gcn_argmax_classifier dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .read_row      (read_row),
    .fm_wm_adj_out (mem_rd),
    .y             (y),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  // Combinational read port of the result memory.
  always_comb begin
    for (int c = 0; c < int'(WC); c++) begin
      mem_rd[c] = (read_row < FW'(FR)) ? mem[read_row][c] : '0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [YW-1:0] y_flat();
    logic [YW-1:0] f;
    f = '0;
    for (int r = 0; r < int'(FR); r++) f[r*WW +: WW] = y[r];
    return f;
  endfunction

  // Reference argmax: first index holding the largest unsigned score.
  function automatic logic [YW-1:0] ref_argmax();
    logic [YW-1:0] f;
    logic [DW-1:0] best_v;
    int            best_i;
    f = '0;
    for (int r = 0; r < int'(FR); r++) begin
      best_i = 0;
      best_v = mem[r][0];
      for (int c = 1; c < int'(WC); c++) begin
        if (mem[r][c] > best_v) begin
          best_v = mem[r][c];
          best_i = c;
        end
      end
      f[r*WW +: WW] = WW'(best_i);
    end
    return f;
  endfunction

  function automatic logic [YW-1:0] pack_classes(input int c0, input int c1, input int c2,
                                                 input int c3, input int c4, input int c5);
    logic [YW-1:0] f;
    f = {WW'(c5), WW'(c4), WW'(c3), WW'(c2), WW'(c1), WW'(c0)};
    return f;
  endfunction

  task automatic set_row(input int r, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [DW-1:0] c);
    mem[r][0] = a;
    mem[r][1] = b;
    mem[r][2] = c;
  endtask

  task automatic load_distinct();
    set_row(0, 16'd1, 16'd5, 16'd2);
    set_row(1, 16'd9, 16'd3, 16'd4);
    set_row(2, 16'd0, 16'd0, 16'd7);
    set_row(3, 16'd8, 16'd8, 16'd1);
    set_row(4, 16'd2, 16'd6, 16'd6);
    set_row(5, 16'd3, 16'd1, 16'd0);
  endtask

  task automatic fill_rand(input int unsigned hi);
    for (int r = 0; r < int'(FR); r++)
      for (int c = 0; c < int'(WC); c++)
        mem[r][c] = DW'($urandom_range(hi, 0));
  endtask

  // One full pass; pa/pb are cycles at which a stray start pulse is injected.
  task automatic run_pass(input logic [YW-1:0] exp_y, input int pa, input int pb);
    int cycles;
    int busy_cnt;
    exp_q.push_back(exp_y);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("y_clear", 32'(y_flat()), 32'd0);
    check("busy_on", 32'(busy), 32'd1);
    check("addr0", 32'(read_row), 32'd0);
    busy_cnt = int'(busy);
    cycles   = 0;
    while (!done && cycles < 100) begin
      @(posedge clk);
      #1;
      cycles++;
      start = (cycles == pa) || (cycles == pb);
      if (!done) begin
        busy_cnt += int'(busy);
        check("addr_seq", 32'(read_row), 32'(cycles / 4));
      end
      if (done && exp_q.size() > 0) check("y_final", 32'(y_flat()), 32'(exp_q.pop_front()));
    end
    start = 1'b0;
    check("done_lat", 32'(cycles), 32'd24);
    check("busy_cycles", 32'(busy_cnt), 32'd24);
    check("busy_at_done", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    check("done_pulse", 32'(done), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("y_hold", 32'(y_flat()), 32'(exp_y));
  endtask

  initial begin
    load_distinct();
    repeat (3) @(posedge clk);
    #1;
    check("rst_addr", 32'(read_row), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_y", 32'(y_flat()), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Distinct maxima and ties.
    run_pass(pack_classes(1, 0, 2, 0, 1, 0), -1, -1);

    // Extreme unsigned values with stray start pulses mid-pass.
    fill_rand(16'hFFFF);
    set_row(0, 16'hFFFF, 16'h0000, 16'hFFFE);
    set_row(1, 16'h0000, 16'h0000, 16'hFFFF);
    run_pass(ref_argmax(), 5, 15);
    check("ext_row0", 32'(y[0]), 32'd0);
    check("ext_row1", 32'(y[1]), 32'd2);

    // Small random scores produce plenty of ties.
    fill_rand(3);
    run_pass(ref_argmax(), -1, -1);

    // Reset during CMP of row 3.
    load_distinct();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (13) @(posedge clk);
    #1;
    check("pre_rst_row", 32'(read_row), 32'd3);
    check("pre_rst_y", 32'(y_flat()), 32'(pack_classes(1, 0, 2, 0, 0, 0)));
    rst = 1'b0;
    #1;
    check("midrst_addr", 32'(read_row), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_y", 32'(y_flat()), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    run_pass(pack_classes(1, 0, 2, 0, 1, 0), -1, -1);

    // All-zero memory.
    fill_rand(0);
    run_pass(pack_classes(0, 0, 0, 0, 0, 0), -1, -1);

    check("sb_left", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
